// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide request scheduler.
package md_pkg;

  // Request opcodes as presented by the pipeline on req_op.
  typedef enum logic [2:0] {
    MULT  = 3'b000,
    MULTU = 3'b001,
    DIV   = 3'b010,
    DIVU  = 3'b011,
    MTHI  = 3'b100,
    MTLO  = 3'b101,
    MFHI  = 3'b110,
    MFLO  = 3'b111
  } md_op_e;

  // Scheduler states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } md_state_e;

  localparam int MD_QDEPTH    = 2;
  localparam int MD_PAYLOAD_W = 67;

  // One queued operation: opcode plus both operands.
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  // mfhi/mflo are the only ops that read HI/LO instead of queueing work.
  function automatic logic is_mf(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_fifo.sv
// Two-entry FIFO holding pending {op, a, b} entries for the MD unit.
module md_fifo
  import md_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [MD_PAYLOAD_W-1:0] din,
  input  logic                    pop,
  output logic [MD_PAYLOAD_W-1:0] dout,
  output logic                    full,
  output logic                    empty,
  output logic [1:0]              count
);

  logic [MD_PAYLOAD_W-1:0] mem [MD_QDEPTH];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              cnt;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'(MD_QDEPTH));
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/md_sched.sv
// Queues committed multiply/divide/HI-LO writes, issues them one at a time to
// the MD unit, and answers mfhi/mflo once all queued work has drained.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready may depend combinationally on req_op,
// req_b and the current queue/MD state, and the pipeline holds its request
// stable while req_valid is high and req_ready is low.
module md_sched
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        md_start,
  output logic [2:0]  md_opt,
  output logic [31:0] md_v1,
  output logic [31:0] md_v2,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [1:0]  q_count,
  output logic [1:0]  dbg_state
);

  md_state_e               state;
  logic                    req_mf;
  logic                    req_div0;
  logic                    push;
  logic                    pop;
  logic                    have_work;
  logic                    go_issue;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [MD_PAYLOAD_W-1:0] fifo_din;
  logic [MD_PAYLOAD_W-1:0] fifo_dout;
  md_entry_t               next_head;

  assign req_mf   = is_mf(req_op);
  // Divide by zero is swallowed: accepted but never reaches the MD unit.
  assign req_div0 = (req_op[2:1] == 2'b01) && (req_b == 32'd0);
  assign push     = req_valid && !req_mf && !fifo_full && !req_div0;
  assign pop      = (state == ISSUE);
  assign fifo_din = {req_op, req_a, req_b};

  md_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  // Ready/read-data: MD ops wait only for queue space; mf ops wait for the
  // queue and the MD unit to go fully quiet so HI/LO are final.
  always_comb begin
    req_ready = 1'b1;
    rdata     = 32'd0;
    if (req_valid) begin
      if (req_mf) begin
        req_ready = fifo_empty && !md_busy && !md_start;
        if (req_ready) rdata = req_op[0] ? md_lo : md_hi;
      end else begin
        req_ready = !fifo_full;
      end
    end
  end

  // The entry that will be at the head after this edge. Only when the queue
  // is empty can that be the entry being pushed right now.
  assign next_head = fifo_empty ? md_entry_t'(fifo_din) : md_entry_t'(fifo_dout);
  assign have_work = !fifo_empty || push;
  assign go_issue  = have_work &&
                     ((state == IDLE) || ((state == WAIT) && !md_busy));

  // Scheduler FSM with registered start pulse and operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      md_start <= 1'b0;
      md_opt   <= 3'd0;
      md_v1    <= 32'd0;
      md_v2    <= 32'd0;
    end else begin
      case (state)
        IDLE:    if (go_issue) state <= ISSUE;
        ISSUE:   state <= WAIT;
        WAIT:    if (!md_busy) state <= go_issue ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
      if (go_issue) begin
        md_start <= 1'b1;
        md_opt   <= next_head.op;
        md_v1    <= next_head.a;
        md_v2    <= next_head.b;
      end else begin
        md_start <= 1'b0;
        md_opt   <= 3'd0;
        md_v1    <= 32'd0;
        md_v2    <= 32'd0;
      end
    end
  end

  assign dbg_state = state;

endmodule
